// File: rtl/ntt_div_seq.sv
// Sequential radix-2 restoring divider: 2*RADIX-bit dividend by RADIX-bit divisor.
// One quotient bit per cycle in BUSY; results are held in DONE until consumed.
module ntt_div_seq #(
  parameter int RADIX = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 zeroize,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2*RADIX-1:0]   A_i,
  input  logic [RADIX-1:0]     B_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*RADIX-1:0]   Q_o,
  output logic [RADIX-1:0]     R_o,
  output logic                 div0_o
);

  localparam int W2 = 2 * RADIX;
  localparam int CW = $clog2(W2 + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [W2-1:0]     dvd;
  logic [RADIX-1:0]  dvs;
  logic [W2-1:0]     quo;
  logic [RADIX-1:0]  rem;

  logic [RADIX:0]    part;
  logic [RADIX:0]    diff;
  logic              ge;
  logic [RADIX-1:0]  rem_n;
  logic [W2-1:0]     quo_n;

  // Restoring step: partial remainder is always < 2*B, so it fits in RADIX+1.
  always_comb begin
    part  = {rem, dvd[W2-1]};
    diff  = part - {1'b0, dvs};
    ge    = (part >= {1'b0, dvs});
    rem_n = ge ? diff[RADIX-1:0] : part[RADIX-1:0];
    quo_n = {quo[W2-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      quo     <= '0;
      rem     <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      Q_o     <= '0;
      R_o     <= '0;
      div0_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            dvd     <= A_i;
            dvs     <= B_i;
            quo     <= '0;
            rem     <= '0;
            ready_o <= 1'b0;
            if (B_i == '0) begin
              state   <= DONE;
              valid_o <= 1'b1;
              Q_o     <= '1;
              R_o     <= A_i[RADIX-1:0];
              div0_o  <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CW'(W2);
            end
          end
        end
        BUSY: begin
          dvd <= {dvd[W2-2:0], 1'b0};
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= DONE;
            valid_o <= 1'b1;
            Q_o     <= quo_n;
            R_o     <= rem_n;
          end
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            dvd     <= '0;
            dvs     <= '0;
            quo     <= '0;
            rem     <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            Q_o     <= '0;
            R_o     <= '0;
            div0_o  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
